byte_striping_n: RTL



---
 rtl/byte_striping_n_pkg.sv | 17 +
 rtl/byte_striping_n_stripe_stage.sv | 66 ++++++
 rtl/byte_striping_n.sv | 69 ++++++
 3 files changed

// File: rtl/byte_striping_n_pkg.sv
// Shared helpers for the N-lane byte striper: lane slicing, pointer sizing
// and parameter legality.
package byte_striping_n_pkg;

   function automatic int ptr_w(input int lanes);
      return $clog2(lanes);
   endfunction

   function automatic int lane_lo(input int i, input int width);
      return i * width;
   endfunction

   function automatic bit lanes_legal(input int lanes);
      return (lanes >= 2) && (lanes <= 8) && ((lanes & (lanes - 1)) == 0);
   endfunction

endpackage

// File: rtl/byte_striping_n_stripe_stage.sv
// Staging registers and fill pointer; decides when a (full or partial) group
// is ready to move into the output register and what it looks like.
module stripe_stage
   import byte_striping_n_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int LANES = 2
) (
   input  logic                   clk_2f,
   input  logic                   reset_L,
   input  logic                   valid_in,
   input  logic [WIDTH-1:0]       data_in,
   input  logic                   flush,
   input  logic                   slot_free,
   output logic                   in_ready,
   output logic                   load,
   output logic [LANES*WIDTH-1:0] load_data,
   output logic [LANES-1:0]       load_mask
);

   localparam int PTR_W = ptr_w(LANES);

   logic [PTR_W-1:0] ptr;
   logic [WIDTH-1:0] stage [LANES];
   logic             accept;
   logic             last_lane;
   logic             flush_go;
   logic [PTR_W:0]   fill;

   assign last_lane = (ptr == PTR_W'(LANES - 1));
   assign in_ready  = slot_free || (!last_lane && !flush);
   assign accept    = valid_in && in_ready;
   // A flush is only honoured when the output slot can take the group.
   assign flush_go  = flush && slot_free;
   assign load      = (accept && last_lane) || (flush_go && (ptr != '0 || accept));
   assign fill      = {1'b0, ptr} + (PTR_W+1)'(accept);

   always_comb begin
      load_data = '0;
      load_mask = '0;
      for (int i = 0; i < LANES; i++) begin
         if ((PTR_W+1)'(i) < fill)
            load_mask[i] = 1'b1;
         if (PTR_W'(i) < ptr)
            load_data[lane_lo(i, WIDTH) +: WIDTH] = stage[i];
         else if (PTR_W'(i) == ptr && accept)
            load_data[lane_lo(i, WIDTH) +: WIDTH] = data_in;
      end
   end

   always_ff @(posedge clk_2f or negedge reset_L) begin
      if (!reset_L) begin
         ptr <= '0;
         for (int i = 0; i < LANES; i++)
            stage[i] <= '0;
      end else begin
         if (accept)
            stage[ptr] <= data_in;
         if (load)
            ptr <= '0;
         else if (accept)
            ptr <= ptr + PTR_W'(1);
      end
   end

endmodule

// File: rtl/byte_striping_n.sv
// N-lane round-robin byte striper: stages input words, presents complete or
// flushed groups on all lanes with a valid/ready handshake, counts groups.
module byte_striping_n
   import byte_striping_n_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int LANES = 2,
   parameter int CNT_W = 16
) (
   input  logic                   clk_2f,
   input  logic                   reset_L,
   input  logic                   valid_in,
   input  logic [WIDTH-1:0]       data_in,
   output logic                   in_ready,
   input  logic                   flush,
   output logic [LANES*WIDTH-1:0] lane_data,
   output logic [LANES-1:0]       lane_valid,
   input  logic                   out_ready,
   output logic [CNT_W-1:0]       group_count
);

   if (!lanes_legal(LANES) || WIDTH < 1) begin : g_bad_params
      $error("byte_striping_n: LANES must be a power of two in 2..8 and WIDTH >= 1");
   end

   logic                   out_full;
   logic                   slot_free;
   logic                   load;
   logic [LANES*WIDTH-1:0] load_data;
   logic [LANES-1:0]       load_mask;

   assign out_full  = |lane_valid;
   assign slot_free = !out_full || out_ready;

   stripe_stage #(
      .WIDTH (WIDTH),
      .LANES (LANES)
   ) u_stage (
      .clk_2f    (clk_2f),
      .reset_L   (reset_L),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .flush     (flush),
      .slot_free (slot_free),
      .in_ready  (in_ready),
      .load      (load),
      .load_data (load_data),
      .load_mask (load_mask)
   );

   // A new group may load on the same edge the previous one drains.
   always_ff @(posedge clk_2f or negedge reset_L) begin
      if (!reset_L) begin
         lane_data   <= '0;
         lane_valid  <= '0;
         group_count <= '0;
      end else begin
         if (load) begin
            lane_data  <= load_data;
            lane_valid <= load_mask;
            if (group_count != '1)
               group_count <= group_count + CNT_W'(1);
         end else if (out_full && out_ready) begin
            lane_valid <= '0;
         end
      end
   end

endmodule
